// File: rtl/adder_pkg.sv
// adder_pipe shared types: op encoding,
// stage payload and depth limit.
package adder_pkg;

  localparam int MAX_STAGES = 4;
  localparam int MAX_W      = 32;

  typedef enum logic [1:0] {
    ADD = 2'b00,
    SUB = 2'b01,
    ACC = 2'b10,
    CLR = 2'b11
  } op_t;

  // Sized for the widest operand; narrower
  // instances use result[W:0] only.
  typedef struct packed {
    logic [MAX_W:0] result;
    logic           ovf;
  } payload_t;

endpackage

// File: rtl/adder_stage.sv
// adder_pipe pipeline register: one enabled
// payload + valid slot.
module adder_stage
  import adder_pkg::*;
(
  input  logic     clk_i,
  input  logic     rst_ni,
  input  logic     en_i,
  input  logic     valid_i,
  input  payload_t data_i,
  output logic     valid_o,
  output payload_t data_o
);

  logic     valid_q;
  payload_t data_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      valid_q <= 1'b0;
      data_q  <= '0;
    end else if (en_i) begin
      valid_q <= valid_i;
      data_q  <= data_i;
    end
  end

  assign valid_o = valid_q;
  assign data_o  = data_q;

endmodule

// File: rtl/adder_pipe.sv
// adder_pipe: add/sub/accumulate unit with a
// valid/ready pipeline of G_STAGES registers.
module adder_pipe
  import adder_pkg::*;
#(
  parameter int G_DATA_WIDTH = 8,
  parameter int G_STAGES     = 2,
  parameter int G_SATURATE   = 0
) (
  input  logic                    i_clk,
  input  logic                    i_rst_n,
  input  logic                    i_valid,
  output logic                    o_ready,
  input  logic [G_DATA_WIDTH-1:0] i_A,
  input  logic [G_DATA_WIDTH-1:0] i_B,
  input  logic [1:0]              i_op,
  output logic                    o_valid,
  input  logic                    i_ready,
  output logic [G_DATA_WIDTH:0]   o_C,
  output logic                    o_ovf
);

  localparam int W = G_DATA_WIDTH;

  if (W < 2 || W > MAX_W ||
      G_STAGES < 1 || G_STAGES > MAX_STAGES) begin : g_bad
    $error("adder_pipe: illegal parameters");
  end

  logic         rdy_q;
  logic         advance;
  logic         xfer;
  logic [W:0]   acc_q;
  logic [W:0]   acc_d;
  logic [W+1:0] acc_sum;
  op_t          op;
  payload_t     pl_d;
  payload_t     pl [G_STAGES+1];
  logic         v  [G_STAGES+1];

  // Whole pipe moves as one; only a held
  // output can stall it.
  assign advance = !(o_valid && !i_ready);
  assign o_ready = rdy_q && advance;
  assign xfer    = i_valid && o_ready;
  assign op      = op_t'(i_op);
  assign acc_sum = {1'b0, acc_q} + {2'b00, i_A};

  always_comb begin
    pl_d  = '0;
    acc_d = acc_q;
    unique case (1'b1)
      (op == ADD): begin
        pl_d.result[W:0] = {1'b0, i_A} + {1'b0, i_B};
      end
      (op == SUB): begin
        pl_d.result[W:0] = {1'b0, i_A} - {1'b0, i_B};
        pl_d.ovf         = i_A < i_B;
      end
      (op == ACC): begin
        pl_d.ovf = acc_sum[W+1];
        acc_d    = (acc_sum[W+1] && G_SATURATE != 0)
                   ? '1 : acc_sum[W:0];
        pl_d.result[W:0] = acc_d;
      end
      (op == CLR): begin
        acc_d = '0;
      end
      default: ;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      rdy_q <= 1'b0;
      acc_q <= '0;
    end else begin
      rdy_q <= 1'b1;
      if (xfer) acc_q <= acc_d;
    end
  end

  assign pl[0] = pl_d;
  assign v[0]  = xfer;

  for (genvar s = 0; s < G_STAGES; s++) begin : g_stage
    adder_stage u_stage (
      .clk_i   (i_clk),
      .rst_ni  (i_rst_n),
      .en_i    (advance),
      .valid_i (v[s]),
      .data_i  (pl[s]),
      .valid_o (v[s+1]),
      .data_o  (pl[s+1])
    );
  end

  assign o_valid = v[G_STAGES];
  assign o_C     = pl[G_STAGES].result[W:0];
  assign o_ovf   = pl[G_STAGES].ovf;

  if (W < MAX_W) begin : g_hi
    logic unused_hi;
    assign unused_hi = |pl[G_STAGES].result[MAX_W:W+1];
  end

endmodule
